// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one pipelined single-port SRAM.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin ties (default: data wins ties).
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_INST,
    PEND_DATA
  } pend_t;

  pend_t pend;
  logic  pend_wr;
  logic  last_grant;  // 1 = data was granted last
  logic  grant_inst;
  logic  grant_data;
  logic  data_side;

  // Grants are suppressed while reset is high so the first grant lands in the first free cycle.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (inst_req && data_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        grant_data = !last_grant;
        grant_inst = last_grant;
`else
        grant_data = 1'b1;
`endif
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

`ifndef SRAM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign data_side    = grant_data || (!grant_inst && data_req);
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign sram_en      = grant_inst || grant_data;
  assign sram_we      = grant_data && data_wr;
  assign sram_addr    = data_side ? data_addr : inst_addr;
  assign sram_wdata   = data_side ? data_wdata : '0;

  assign inst_data_ok = (pend == PEND_INST);
  assign data_data_ok = (pend == PEND_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
  assign data_rdata   = (data_data_ok && !pend_wr) ? sram_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= PEND_NONE;
      pend_wr    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_inst) begin
      pend       <= PEND_INST;
      pend_wr    <= 1'b0;
      last_grant <= 1'b0;
    end else if (grant_data) begin
      pend       <= PEND_DATA;
      pend_wr    <= data_wr;
      last_grant <= 1'b1;
    end else begin
      pend       <= PEND_NONE;
      pend_wr    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table, hand sequences and a response scoreboard.
// Honours SRAM_ARB_ROUND_ROBIN_EN for the tie sequence.
module tb_sram_port_arbiter;

  localparam logic [31:0] A0 = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SRAM model: written locations remembered, others return an address-derived pattern
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == A0) return 32'h0280_0421;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] = sram_wdata;
      else sram_rdata = rd(sram_addr);
    end
  end

  // Scoreboard: expected response data and due cycle, pushed at grant time
  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;
  exp_t iq[$];
  exp_t dq[$];
  exp_t ie, de;

  always @(negedge clk) begin
    if (reset) begin
      iq.delete();
      dq.delete();
      chk("reset_ctrl", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we}, '0);
      chk("reset_rdata", {inst_rdata, data_rdata}, '0);
    end else begin
      if (inst_data_ok) begin
        if (iq.size() == 0) chk("inst_data_ok_unexpected", inst_data_ok, 0);
        else begin
          ie = iq.pop_front();
          chk("inst_rdata", inst_rdata, ie.data);
          chk("inst_latency", cyc, ie.due);
        end
      end else if (iq.size() != 0 && iq[0].due <= cyc) begin
        chk("inst_data_ok_missing", inst_data_ok, 1);
        void'(iq.pop_front());
      end
      if (data_data_ok) begin
        if (dq.size() == 0) chk("data_data_ok_unexpected", data_data_ok, 0);
        else begin
          de = dq.pop_front();
          chk("data_rdata", data_rdata, de.data);
          chk("data_latency", cyc, de.due);
        end
      end else if (dq.size() != 0 && dq[0].due <= cyc) begin
        chk("data_data_ok_missing", data_data_ok, 1);
        void'(dq.pop_front());
      end
      if (inst_addr_ok) iq.push_back('{rd(inst_addr), cyc + 1});
      if (data_addr_ok) dq.push_back('{(data_wr ? 32'h0 : rd(data_addr)), cyc + 1});
    end
  end

  typedef struct {
    string       nm;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  e_ctl;   // {inst_addr_ok, data_addr_ok, sram_en, sram_we}
    logic [31:0] e_addr;
    logic [31:0] e_wd;
  } vec_t;
  vec_t tv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_addr = da; data_wdata = dd;
  endtask

  initial begin
    tv[0] = '{"idle_mux",  1'b0, 32'h55,  1'b0, 1'b1, 32'h77,  32'h99,        4'b0000, 32'h55,    32'h0};
    tv[1] = '{"lone_fetch",1'b1, A0,      1'b0, 1'b0, 32'h0,   32'h0,         4'b1010, A0,        32'h0};
    tv[2] = '{"store",     1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'hDEADBEEF,  4'b0111, 32'h100,   32'hDEADBEEF};
    tv[3] = '{"load",      1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h12345678,  4'b0110, 32'h100,   32'h12345678};
    tv[4] = '{"fetch_a",   1'b1, A0 + 4,  1'b0, 1'b0, 32'h0,   32'h0,         4'b1010, A0 + 4,    32'h0};
    tv[5] = '{"fetch_b",   1'b1, A0 + 8,  1'b0, 1'b0, 32'h0,   32'h0,         4'b1010, A0 + 8,    32'h0};
    tv[6] = '{"idle_iaddr",1'b0, A0 + 12, 1'b0, 1'b0, 32'h200, 32'hAA,        4'b0000, A0 + 12,   32'h0};
    tv[7] = '{"idle_zero", 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         4'b0000, 32'h0,     32'h0};

    // Reset with both requesters asserting: outputs must stay quiet
    reset = 1'b1;
    drive(1'b1, A0, 1'b1, 1'b1, 32'h40, 32'h1);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
      @(negedge clk);
      chk({tv[i].nm, "_ctl"}, {inst_addr_ok, data_addr_ok, sram_en, sram_we}, tv[i].e_ctl);
      chk({tv[i].nm, "_addr"}, sram_addr, tv[i].e_addr);
      chk({tv[i].nm, "_wdata"}, sram_wdata, tv[i].e_wd);
      step();
    end
    step();

    // Back-to-back fetches, one access per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, A0 + 32'h40 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("b2b_grant", {inst_addr_ok, sram_en, sram_we}, 3'b110);
      chk("b2b_addr", sram_addr, A0 + 32'h40 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_idle_after", sram_en, 1'b0);
    step();
    step();

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    drive(1'b1, A0 + 32'h100, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("tie_grant", {inst_addr_ok, data_addr_ok}, 2'b01);
    step();
    data_req = 1'b0;
    @(negedge clk);
    chk("tie_loser_grant", {inst_addr_ok, data_addr_ok}, 2'b10);
    step();
`else
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b1, A0 + 32'h100, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("rr_tie1", {inst_addr_ok, data_addr_ok}, 2'b10);
    step();
    inst_addr = A0 + 32'h104;
    @(negedge clk);
    chk("rr_tie2", {inst_addr_ok, data_addr_ok}, 2'b01);
    step();
    data_addr = 32'h104;
    @(negedge clk);
    chk("rr_tie3", {inst_addr_ok, data_addr_ok}, 2'b10);
    step();
    inst_req = 1'b0;
    @(negedge clk);
    chk("rr_tail", {inst_addr_ok, data_addr_ok}, 2'b01);
    step();
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Reset pulse while a load response is due: the response must vanish
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    chk("mid_rst_grant", data_addr_ok, 1'b1);
    step();
    data_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_drop", data_data_ok, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0);
    @(negedge clk);
    chk("post_rst_grant", {data_addr_ok, sram_en}, 2'b11);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) step();

    @(negedge clk);
    chk("queue_drain", iq.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
